sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 31 +++
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM fetch/data arbiter.
// Holds FSM state encodings, owner codes and bus widths used by sram_arbiter.
package sram_arbiter_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic CHIP_ENABLE = 1'b1;
    localparam logic STOP        = 1'b1;
    localparam logic NO_STOP     = 1'b0;

    localparam int INST_ADDR_W = 32;
    localparam int REG_W       = 32;
    localparam int SRAM_ADDR_W = 20;
    localparam int BE_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_e;

    // Byte address to SRAM word address; top and byte-offset bits are dropped.
    function automatic logic [SRAM_ADDR_W-1:0] word_addr(input logic [INST_ADDR_W-1:0] byte_addr);
        word_addr = byte_addr[21:2];
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Shares one single-ported SRAM between the instruction-fetch and data ports.
// Three-state access sequence (IDLE, ACC, DONE); the data port has fixed priority.
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_ce_i,
    input  logic [INST_ADDR_W-1:0] if_addr_i,
    output logic [REG_W-1:0]       if_inst_o,
    output logic                   if_stallreq_o,

    input  logic                   mem_ce_i,
    input  logic                   mem_we_i,
    input  logic [BE_W-1:0]        mem_sel_i,
    input  logic [REG_W-1:0]       mem_addr_i,
    input  logic [REG_W-1:0]       mem_data_i,
    output logic [REG_W-1:0]       mem_data_o,
    output logic                   mem_stallreq_o,

    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    output logic [REG_W-1:0]       sram_data_o,
    input  logic [REG_W-1:0]       sram_data_i,
    output logic                   sram_ce_n_o,
    output logic                   sram_oe_n_o,
    output logic                   sram_we_n_o,
    output logic [BE_W-1:0]        sram_be_n_o
);

    arb_state_e             state_r;
    arb_state_e             state_next_s;
    arb_owner_e             own_r;
    logic [SRAM_ADDR_W-1:0] lat_addr_r;
    logic                   lat_we_r;
    logic [BE_W-1:0]        lat_sel_r;
    logic [REG_W-1:0]       lat_data_r;
    logic [REG_W-1:0]       if_inst_r;
    logic [REG_W-1:0]       mem_data_r;
    logic                   done_inst_s;
    logic                   done_data_s;
    logic                   unused_addr_bits_s;

    assign unused_addr_bits_s = ^{if_addr_i[31:22], if_addr_i[1:0],
                                  mem_addr_i[31:22], mem_addr_i[1:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: data request wins in IDLE, ACC and DONE last one cycle each.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if ((mem_ce_i == CHIP_ENABLE) || (if_ce_i == CHIP_ENABLE)) begin
                    state_next_s = ST_ACC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACC:  state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Request latch: the winning request is frozen so the access survives input changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            own_r      <= OWN_INST;
            lat_addr_r <= {SRAM_ADDR_W{1'b0}};
            lat_we_r   <= 1'b0;
            lat_sel_r  <= {BE_W{1'b0}};
            lat_data_r <= {REG_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (mem_ce_i == CHIP_ENABLE) begin
                own_r      <= OWN_DATA;
                lat_addr_r <= word_addr(mem_addr_i);
                lat_we_r   <= mem_we_i;
                lat_sel_r  <= mem_sel_i;
                lat_data_r <= mem_data_i;
            end else if (if_ce_i == CHIP_ENABLE) begin
                own_r      <= OWN_INST;
                lat_addr_r <= word_addr(if_addr_i);
                lat_we_r   <= 1'b0;
                lat_sel_r  <= 4'hF;
                lat_data_r <= {REG_W{1'b0}};
            end else begin
                own_r      <= own_r;
                lat_addr_r <= lat_addr_r;
                lat_we_r   <= lat_we_r;
                lat_sel_r  <= lat_sel_r;
                lat_data_r <= lat_data_r;
            end
        end else begin
            own_r      <= own_r;
            lat_addr_r <= lat_addr_r;
            lat_we_r   <= lat_we_r;
            lat_sel_r  <= lat_sel_r;
            lat_data_r <= lat_data_r;
        end
    end

    // Read capture at the end of ACC into the owner's result register only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            if_inst_r  <= {REG_W{1'b0}};
            mem_data_r <= {REG_W{1'b0}};
        end else if ((state_r == ST_ACC) && !lat_we_r) begin
            if (own_r == OWN_INST) begin
                if_inst_r  <= sram_data_i;
                mem_data_r <= mem_data_r;
            end else begin
                if_inst_r  <= if_inst_r;
                mem_data_r <= sram_data_i;
            end
        end else begin
            if_inst_r  <= if_inst_r;
            mem_data_r <= mem_data_r;
        end
    end

    // SRAM strobes decoded from the state register so reset deasserts them at once.
    always_comb begin
        sram_ce_n_o = 1'b1;
        sram_oe_n_o = 1'b1;
        sram_we_n_o = 1'b1;
        sram_be_n_o = 4'hF;
        if (state_r == ST_ACC) begin
            sram_ce_n_o = 1'b0;
            if (lat_we_r) begin
                sram_oe_n_o = 1'b1;
                sram_we_n_o = 1'b0;
                sram_be_n_o = ~lat_sel_r;
            end else begin
                sram_oe_n_o = 1'b0;
                sram_we_n_o = 1'b1;
                sram_be_n_o = 4'h0;
            end
        end else begin
            sram_ce_n_o = 1'b1;
        end
    end

    assign sram_addr_o = lat_addr_r;
    assign sram_data_o = lat_data_r;
    assign if_inst_o   = if_inst_r;
    assign mem_data_o  = mem_data_r;

    assign done_inst_s    = (state_r == ST_DONE) && (own_r == OWN_INST);
    assign done_data_s    = (state_r == ST_DONE) && (own_r == OWN_DATA);
    assign if_stallreq_o  = (if_ce_i == CHIP_ENABLE) && !done_inst_s;
    assign mem_stallreq_o = (mem_ce_i == CHIP_ENABLE) && !done_data_s;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_stallreq_o;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_stallreq_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_data_o;
    logic [31:0] sram_data_i;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    int checks = 0;
    int errors = 0;

    sram_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_ce_i        (if_ce_i),
        .if_addr_i      (if_addr_i),
        .if_inst_o      (if_inst_o),
        .if_stallreq_o  (if_stallreq_o),
        .mem_ce_i       (mem_ce_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .mem_stallreq_o (mem_stallreq_o),
        .sram_addr_o    (sram_addr_o),
        .sram_data_o    (sram_data_o),
        .sram_data_i    (sram_data_i),
        .sram_ce_n_o    (sram_ce_n_o),
        .sram_oe_n_o    (sram_oe_n_o),
        .sram_we_n_o    (sram_we_n_o),
        .sram_be_n_o    (sram_be_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle; inputs are applied and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        if_ce_i     = 1'b0;
        if_addr_i   = 32'h0;
        mem_ce_i    = 1'b0;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'h0;
        mem_addr_i  = 32'h0;
        mem_data_i  = 32'h0;
        sram_data_i = 32'h0;

        // Reset state
        #12;
        chk("rst_if_inst",  if_inst_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        chk("rst_ce_n",     32'(sram_ce_n_o), 32'd1);
        chk("rst_be_n",     32'(sram_be_n_o), 32'hF);
        chk("rst_if_stall_idle", 32'(if_stallreq_o), 32'd0);
        if_ce_i = 1'b1;
        #1;
        chk("rst_if_stall_req", 32'(if_stallreq_o), 32'd1);
        if_ce_i = 1'b0;
        step();
        rst = 1'b0;

        // Fetch only
        step();
        if_ce_i     = 1'b1;
        if_addr_i   = 32'h8000_0010;
        sram_data_i = 32'h2408_0001;
        #1;
        chk("f_c1_stall", 32'(if_stallreq_o), 32'd1);
        chk("f_c1_ce_n",  32'(sram_ce_n_o), 32'd1);
        step();
        chk("f_c2_ce_n",  32'(sram_ce_n_o), 32'd0);
        chk("f_c2_oe_n",  32'(sram_oe_n_o), 32'd0);
        chk("f_c2_we_n",  32'(sram_we_n_o), 32'd1);
        chk("f_c2_be_n",  32'(sram_be_n_o), 32'h0);
        chk("f_c2_addr",  32'(sram_addr_o), 32'h00004);
        chk("f_c2_stall", 32'(if_stallreq_o), 32'd1);
        step();
        chk("f_c3_inst",  if_inst_o, 32'h2408_0001);
        chk("f_c3_stall", 32'(if_stallreq_o), 32'd0);
        chk("f_c3_ce_n",  32'(sram_ce_n_o), 32'd1);
        if_ce_i = 1'b0;
        step();

        // Byte write, request dropped during ACC
        mem_ce_i   = 1'b1;
        mem_we_i   = 1'b1;
        mem_sel_i  = 4'b0100;
        mem_addr_i = 32'h8000_0102;
        mem_data_i = 32'h00AB_0000;
        #1;
        chk("w_c1_stall", 32'(mem_stallreq_o), 32'd1);
        step();
        mem_ce_i   = 1'b0;
        mem_we_i   = 1'b0;
        mem_sel_i  = 4'h0;
        mem_addr_i = 32'h0;
        mem_data_i = 32'h0;
        #1;
        chk("w_c2_ce_n", 32'(sram_ce_n_o), 32'd0);
        chk("w_c2_we_n", 32'(sram_we_n_o), 32'd0);
        chk("w_c2_oe_n", 32'(sram_oe_n_o), 32'd1);
        chk("w_c2_be_n", 32'(sram_be_n_o), 32'b1011);
        chk("w_c2_addr", 32'(sram_addr_o), 32'h00040);
        chk("w_c2_data", sram_data_o, 32'h00AB_0000);
        step();
        chk("w_c3_ce_n", 32'(sram_ce_n_o), 32'd1);
        chk("w_c3_we_n", 32'(sram_we_n_o), 32'd1);
        step();
        chk("w_c4_idle_ce_n", 32'(sram_ce_n_o), 32'd1);

        // Conflict: data read first, fetch follows
        step();
        if_ce_i     = 1'b1;
        if_addr_i   = 32'h8000_0020;
        mem_ce_i    = 1'b1;
        mem_we_i    = 1'b0;
        mem_sel_i   = 4'hF;
        mem_addr_i  = 32'h8000_0200;
        sram_data_i = 32'hDDDD_0001;
        #1;
        chk("c_c1_mstall", 32'(mem_stallreq_o), 32'd1);
        chk("c_c1_istall", 32'(if_stallreq_o), 32'd1);
        step();
        chk("c_c2_addr",   32'(sram_addr_o), 32'h00080);
        chk("c_c2_istall", 32'(if_stallreq_o), 32'd1);
        step();
        chk("c_c3_mstall", 32'(mem_stallreq_o), 32'd0);
        chk("c_c3_mdata",  mem_data_o, 32'hDDDD_0001);
        chk("c_c3_istall", 32'(if_stallreq_o), 32'd1);
        mem_ce_i    = 1'b0;
        sram_data_i = 32'h1111_2222;
        step();
        chk("c_c4_istall", 32'(if_stallreq_o), 32'd1);
        chk("c_c4_ce_n",   32'(sram_ce_n_o), 32'd1);
        step();
        chk("c_c5_addr",   32'(sram_addr_o), 32'h00008);
        chk("c_c5_istall", 32'(if_stallreq_o), 32'd1);
        step();
        chk("c_c6_istall", 32'(if_stallreq_o), 32'd0);
        chk("c_c6_inst",   if_inst_o, 32'h1111_2222);
        chk("c_c6_mdata_hold", mem_data_o, 32'hDDDD_0001);
        if_ce_i = 1'b0;
        step();

        // Held read for 6 cycles: two complete accesses
        mem_ce_i    = 1'b1;
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h8000_0300;
        sram_data_i = 32'hABCD_0001;
        #1;
        chk("h_c1_stall", 32'(mem_stallreq_o), 32'd1);
        step();
        chk("h_c2_stall", 32'(mem_stallreq_o), 32'd1);
        step();
        chk("h_c3_stall", 32'(mem_stallreq_o), 32'd0);
        chk("h_c3_data",  mem_data_o, 32'hABCD_0001);
        sram_data_i = 32'hABCD_0002;
        step();
        chk("h_c4_stall", 32'(mem_stallreq_o), 32'd1);
        step();
        chk("h_c5_stall", 32'(mem_stallreq_o), 32'd1);
        chk("h_c5_ce_n",  32'(sram_ce_n_o), 32'd0);
        step();
        chk("h_c6_stall", 32'(mem_stallreq_o), 32'd0);
        chk("h_c6_data",  mem_data_o, 32'hABCD_0002);
        chk("h_c6_inst_hold", if_inst_o, 32'h1111_2222);
        mem_ce_i = 1'b0;
        step();

        // Reset asserted mid-ACC
        mem_ce_i    = 1'b1;
        mem_addr_i  = 32'h8000_0400;
        sram_data_i = 32'h5555_AAAA;
        step();
        chk("r_c2_ce_n", 32'(sram_ce_n_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("r_async_ce_n",  32'(sram_ce_n_o), 32'd1);
        chk("r_async_oe_n",  32'(sram_oe_n_o), 32'd1);
        chk("r_async_mdata", mem_data_o, 32'h0);
        chk("r_async_inst",  if_inst_o, 32'h0);
        chk("r_async_mstall", 32'(mem_stallreq_o), 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk("r_n1_ce_n",  32'(sram_ce_n_o), 32'd1);
        chk("r_n1_mdata", mem_data_o, 32'h0);
        chk("r_n1_stall", 32'(mem_stallreq_o), 32'd1);
        step();
        chk("r_n2_ce_n",  32'(sram_ce_n_o), 32'd0);
        chk("r_n2_addr",  32'(sram_addr_o), 32'h00100);
        chk("r_n2_stall", 32'(mem_stallreq_o), 32'd1);
        step();
        chk("r_n3_stall", 32'(mem_stallreq_o), 32'd0);
        chk("r_n3_mdata", mem_data_o, 32'h5555_AAAA);
        mem_ce_i = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
